// File: rtl/floor_controller.sv
// ---------------------------------------------------------------------------
// floor_controller
//   Four-floor elevator car controller. It latches floor calls, chooses a
//   travel direction, times floor-to-floor travel and door dwell, and drives
//   a seven-segment display with the current floor number (level+1).
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   reset        synchronous, active-high reset
//   enable       1 = run; 0 = state, level, dir and counters freeze
//   req[3:0]     level-sensitive call buttons, one per floor
//   level[1:0]   current car floor
//   moving_up    car is travelling upward
//   moving_down  car is travelling downward
//   door_open    door is open at the current floor
//   pending[3:0] latched outstanding calls
//   sevenseg     active-low segments {dp,g,f,e,d,c,b,a}
// ---------------------------------------------------------------------------
module floor_controller #(
  parameter int TRAVEL_CYCLES = 50000000,
  parameter int DOOR_CYCLES   = 100000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] req,
  output logic [1:0] level,
  output logic       moving_up,
  output logic       moving_down,
  output logic       door_open,
  output logic [3:0] pending,
  output logic [7:0] sevenseg
);

  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_MOVE_UP   = 2'd1,
    S_MOVE_DOWN = 2'd2,
    S_DOOR_OPEN = 2'd3
  } state_t;

  state_t        r_state, w_next_state;
  logic [1:0]    r_level, w_next_level;
  logic          r_dir, w_next_dir;
  logic [TW-1:0] r_tcnt, w_next_tcnt;
  logic [DW-1:0] r_dcnt, w_next_dcnt;
  logic [3:0]    r_pending, w_next_pending;
  logic [3:0]    w_set, w_calls, w_clr;
  logic [1:0]    w_up_level, w_dn_level;
  logic          r_moving_up, r_moving_down, r_door_open;
  logic [7:0]    r_seg;

  function automatic logic calls_above(input logic [3:0] c, input logic [1:0] lv);
    logic any;
    any = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > int'(lv) && c[j]) any = 1'b1;
    end
    return any;
  endfunction

  function automatic logic calls_below(input logic [3:0] c, input logic [1:0] lv);
    logic any;
    any = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j < int'(lv) && c[j]) any = 1'b1;
    end
    return any;
  endfunction

  function automatic logic [7:0] seg_code(input logic [1:0] lv);
    logic [7:0] s;
    case (lv)
      2'd0:    s = 8'hF9;
      2'd1:    s = 8'hA4;
      2'd2:    s = 8'hB0;
      default: s = 8'h99;
    endcase
    return s;
  endfunction

  assign w_up_level = r_level + 2'd1;
  assign w_dn_level = r_level - 2'd1;

  // A press at the floor the car is standing at (idle or door open) is served
  // directly and never becomes a pending call.
  always_comb begin
    w_set = req;
    if (r_state == S_IDLE || r_state == S_DOOR_OPEN) w_set[r_level] = 1'b0;
  end

  // Decisions include this cycle's presses so a call is acted on one cycle
  // after the button is sampled.
  assign w_calls = r_pending | w_set;

  always_comb begin
    w_next_state = r_state;
    w_next_level = r_level;
    w_next_dir   = r_dir;
    w_next_tcnt  = r_tcnt;
    w_next_dcnt  = r_dcnt;
    w_clr        = 4'b0000;
    if (enable) begin
      case (r_state)
        S_IDLE: begin
          w_next_tcnt = '0;
          if (req[r_level] || r_pending[r_level]) begin
            w_next_state   = S_DOOR_OPEN;
            w_next_dcnt    = '0;
            w_clr[r_level] = 1'b1;
          end else if (calls_above(w_calls, r_level) && calls_below(w_calls, r_level)) begin
            w_next_state = r_dir ? S_MOVE_UP : S_MOVE_DOWN;
          end else if (calls_above(w_calls, r_level)) begin
            w_next_state = S_MOVE_UP;
            w_next_dir   = 1'b1;
          end else if (calls_below(w_calls, r_level)) begin
            w_next_state = S_MOVE_DOWN;
            w_next_dir   = 1'b0;
          end
        end
        S_MOVE_UP: begin
          if (r_level == 2'd3) begin
            w_next_state = S_IDLE;
            w_next_tcnt  = '0;
          end else if (r_tcnt == T_LAST) begin
            w_next_tcnt  = '0;
            w_next_level = w_up_level;
            if (w_calls[w_up_level]) begin
              w_next_state      = S_DOOR_OPEN;
              w_next_dcnt       = '0;
              w_clr[w_up_level] = 1'b1;
            end else if (!calls_above(w_calls, w_up_level)) begin
              w_next_state = S_IDLE;
            end
          end else begin
            w_next_tcnt = r_tcnt + TW'(1);
          end
        end
        S_MOVE_DOWN: begin
          if (r_level == 2'd0) begin
            w_next_state = S_IDLE;
            w_next_tcnt  = '0;
          end else if (r_tcnt == T_LAST) begin
            w_next_tcnt  = '0;
            w_next_level = w_dn_level;
            if (w_calls[w_dn_level]) begin
              w_next_state      = S_DOOR_OPEN;
              w_next_dcnt       = '0;
              w_clr[w_dn_level] = 1'b1;
            end else if (!calls_below(w_calls, w_dn_level)) begin
              w_next_state = S_IDLE;
            end
          end else begin
            w_next_tcnt = r_tcnt + TW'(1);
          end
        end
        default: begin // S_DOOR_OPEN
          if (req[r_level]) begin
            w_next_dcnt = '0; // hold-door
          end else if (r_dcnt == D_LAST) begin
            w_next_dcnt = '0;
            if (r_dir && calls_above(w_calls, r_level)) begin
              w_next_state = S_MOVE_UP;
            end else if (!r_dir && calls_below(w_calls, r_level)) begin
              w_next_state = S_MOVE_DOWN;
            end else if (r_dir && calls_below(w_calls, r_level)) begin
              w_next_dir   = 1'b0;
              w_next_state = S_MOVE_DOWN;
            end else if (!r_dir && calls_above(w_calls, r_level)) begin
              w_next_dir   = 1'b1;
              w_next_state = S_MOVE_UP;
            end else begin
              w_next_state = S_IDLE;
            end
          end else begin
            w_next_dcnt = r_dcnt + DW'(1);
          end
        end
      endcase
    end
  end

  // A floor being served in this cycle wins over a fresh press for it.
  assign w_next_pending = w_calls & ~w_clr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_level       <= 2'd0;
      r_dir         <= 1'b1;
      r_tcnt        <= '0;
      r_dcnt        <= '0;
      r_pending     <= 4'b0000;
      r_moving_up   <= 1'b0;
      r_moving_down <= 1'b0;
      r_door_open   <= 1'b0;
      r_seg         <= 8'hF9;
    end else begin
      r_state       <= w_next_state;
      r_level       <= w_next_level;
      r_dir         <= w_next_dir;
      r_tcnt        <= w_next_tcnt;
      r_dcnt        <= w_next_dcnt;
      r_pending     <= w_next_pending;
      r_moving_up   <= (w_next_state == S_MOVE_UP);
      r_moving_down <= (w_next_state == S_MOVE_DOWN);
      r_door_open   <= (w_next_state == S_DOOR_OPEN);
      r_seg         <= seg_code(w_next_level);
    end
  end

  assign level       = r_level;
  assign moving_up   = r_moving_up;
  assign moving_down = r_moving_down;
  assign door_open   = r_door_open;
  assign pending     = r_pending;
  assign sevenseg    = r_seg;

endmodule

// File: tb/tb_floor_controller.sv
// ---------------------------------------------------------------------------
// tb_floor_controller
//   Self-checking bench for floor_controller with TRAVEL_CYCLES=4 and
//   DOOR_CYCLES=3. A behavioural car model (floor number, activity, counters
//   as plain integers) advances on every rising edge; a compare process checks
//   every output against it on each falling edge. Directed scenarios pin both
//   the DUT and the model to hand-computed values, then random traffic runs.
// ---------------------------------------------------------------------------
module tb_floor_controller;

  localparam int TC = 4;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [1:0] level;
  logic       moving_up, moving_down, door_open;
  logic [3:0] pending;
  logic [7:0] sevenseg;

  always #5 clk = ~clk;

  floor_controller #(.TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .level(level), .moving_up(moving_up), .moving_down(moving_down),
    .door_open(door_open), .pending(pending), .sevenseg(sevenseg)
  );

  typedef enum int {M_IDLE, M_UP, M_DOWN, M_DOOR} mode_t;
  mode_t    m_mode = M_IDLE;
  int       m_floor = 0;
  bit       m_dir = 1'b1;
  bit [3:0] m_pend = 4'b0000;
  int       m_travel = 0;
  int       m_door = 0;
  bit       m_valid = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  function automatic logic [7:0] seg_of(int f);
    case (f)
      0: return 8'hF9;
      1: return 8'hA4;
      2: return 8'hB0;
      default: return 8'h99;
    endcase
  endfunction

  // number of calls on floors lo..hi
  function automatic int count_calls(bit [3:0] c, int lo, int hi);
    int n = 0;
    for (int f = lo; f <= hi; f++) if (f >= 0 && f <= 3 && c[f]) n++;
    return n;
  endfunction

  task automatic model_step();
    bit [3:0] calls;
    int arrived, step, ahead, fwd, back;
    if (reset) begin
      m_mode = M_IDLE; m_floor = 0; m_dir = 1'b1; m_pend = 4'b0000;
      m_travel = 0; m_door = 0; m_valid = 1'b1;
      return;
    end
    calls = m_pend;
    for (int i = 0; i < 4; i++)
      if (req[i] && !(i == m_floor && (m_mode == M_IDLE || m_mode == M_DOOR))) calls[i] = 1'b1;
    arrived = -1;
    if (enable) begin
      case (m_mode)
        M_IDLE: begin
          if (req[m_floor] || m_pend[m_floor]) begin
            m_mode = M_DOOR; m_door = 0; arrived = m_floor;
          end else begin
            fwd  = count_calls(calls, m_floor + 1, 3);
            back = count_calls(calls, 0, m_floor - 1);
            if (fwd > 0 && back > 0) m_mode = m_dir ? M_UP : M_DOWN;
            else if (fwd > 0) begin m_mode = M_UP; m_dir = 1'b1; end
            else if (back > 0) begin m_mode = M_DOWN; m_dir = 1'b0; end
          end
        end
        M_UP, M_DOWN: begin
          step = (m_mode == M_UP) ? 1 : -1;
          if (m_floor + step > 3 || m_floor + step < 0) begin
            m_mode = M_IDLE; m_travel = 0;
          end else if (m_travel < TC - 1) begin
            m_travel++;
          end else begin
            m_travel = 0;
            m_floor += step;
            ahead = (step > 0) ? count_calls(calls, m_floor + 1, 3) : count_calls(calls, 0, m_floor - 1);
            if (calls[m_floor]) begin m_mode = M_DOOR; m_door = 0; arrived = m_floor; end
            else if (ahead == 0) m_mode = M_IDLE;
          end
        end
        M_DOOR: begin
          if (req[m_floor]) m_door = 0;
          else if (m_door < DC - 1) m_door++;
          else begin
            m_door = 0;
            fwd  = m_dir ? count_calls(calls, m_floor + 1, 3) : count_calls(calls, 0, m_floor - 1);
            back = m_dir ? count_calls(calls, 0, m_floor - 1) : count_calls(calls, m_floor + 1, 3);
            if (fwd > 0) m_mode = m_dir ? M_UP : M_DOWN;
            else if (back > 0) begin m_dir = !m_dir; m_mode = m_dir ? M_UP : M_DOWN; end
            else m_mode = M_IDLE;
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
    if (arrived >= 0) calls[arrived] = 1'b0;
    m_pend = calls;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // pins the DUT and the model to one hand-computed value
  task automatic pin(string name, logic [31:0] dut_v, logic [31:0] model_v, logic [31:0] lit);
    chk({name, " dut"}, dut_v, lit);
    chk({name, " model"}, model_v, lit);
  endtask

  task automatic exp_all(string tag, int lvl, bit up, bit dn, bit dr, logic [3:0] pend, logic [7:0] seg);
    pin({tag, ".level"}, 32'(level), 32'(m_floor), 32'(lvl));
    pin({tag, ".up"}, 32'(moving_up), 32'(m_mode == M_UP), 32'(up));
    pin({tag, ".down"}, 32'(moving_down), 32'(m_mode == M_DOWN), 32'(dn));
    pin({tag, ".door"}, 32'(door_open), 32'(m_mode == M_DOOR), 32'(dr));
    pin({tag, ".pending"}, 32'(pending), 32'(m_pend), 32'(pend));
    pin({tag, ".seg"}, 32'(sevenseg), 32'(seg_of(m_floor)), 32'(seg));
  endtask

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("level", 32'(level), 32'(m_floor));
      chk("moving_up", 32'(moving_up), 32'(m_mode == M_UP));
      chk("moving_down", 32'(moving_down), 32'(m_mode == M_DOWN));
      chk("door_open", 32'(door_open), 32'(m_mode == M_DOOR));
      chk("pending", 32'(pending), 32'(m_pend));
      chk("sevenseg", 32'(sevenseg), 32'(seg_of(m_floor)));
      chk("status_exclusive", 32'(int'(moving_up) + int'(moving_down) + int'(door_open) <= 1), 32'd1);
    end
  end

  initial begin
    @(negedge clk);
    // reset
    reset = 1'b1; tick(1); reset = 1'b0;
    exp_all("reset", 0, 0, 0, 0, 4'b0000, 8'hF9);

    // single trip 0 -> 2
    req = 4'b0100; tick(1); req = 4'b0000;
    exp_all("trip.start", 0, 1, 0, 0, 4'b0100, 8'hF9);
    tick(4); exp_all("trip.f1", 1, 1, 0, 0, 4'b0100, 8'hA4);
    tick(4); exp_all("trip.f2", 2, 0, 0, 1, 4'b0000, 8'hB0);
    tick(2); exp_all("trip.dwell", 2, 0, 0, 1, 4'b0000, 8'hB0);
    tick(1); exp_all("trip.idle", 2, 0, 0, 0, 4'b0000, 8'hB0);

    // direction priority then reversal, from floor 2 with dir up
    req = 4'b1001; tick(1); req = 4'b0000;
    exp_all("rev.start", 2, 1, 0, 0, 4'b1001, 8'hB0);
    tick(4); exp_all("rev.f3", 3, 0, 0, 1, 4'b0001, 8'h99);
    tick(3); exp_all("rev.turn", 3, 0, 1, 0, 4'b0001, 8'h99);
    tick(4); exp_all("rev.f2", 2, 0, 1, 0, 4'b0001, 8'hB0);
    tick(8); exp_all("rev.f0", 0, 0, 0, 1, 4'b0000, 8'hF9);
    tick(3); exp_all("rev.idle", 0, 0, 0, 0, 4'b0000, 8'hF9);

    // call at current floor with hold-door
    req = 4'b0001; tick(1);
    exp_all("hold.open", 0, 0, 0, 1, 4'b0000, 8'hF9);
    tick(4); exp_all("hold.held", 0, 0, 0, 1, 4'b0000, 8'hF9);
    req = 4'b0000; tick(2);
    exp_all("hold.release", 0, 0, 0, 1, 4'b0000, 8'hF9);
    tick(1); exp_all("hold.closed", 0, 0, 0, 0, 4'b0000, 8'hF9);

    // freeze mid-travel, then reset mid-move
    req = 4'b1000; tick(1); req = 4'b0000;
    exp_all("frz.start", 0, 1, 0, 0, 4'b1000, 8'hF9);
    tick(2);
    enable = 1'b0; req = 4'b0010; tick(1); req = 4'b0000; tick(9);
    exp_all("frz.held", 0, 1, 0, 0, 4'b1010, 8'hF9);
    enable = 1'b1; tick(1);
    exp_all("frz.resume", 0, 1, 0, 0, 4'b1010, 8'hF9);
    tick(1); exp_all("frz.f1", 1, 0, 0, 1, 4'b1000, 8'hA4);
    tick(3); exp_all("frz.onward", 1, 1, 0, 0, 4'b1000, 8'hA4);
    tick(2);
    reset = 1'b1; tick(1); reset = 1'b0;
    exp_all("rst.mid", 0, 0, 0, 0, 4'b0000, 8'hF9);

    // random traffic
    repeat (3000) begin
      reset  = ($urandom_range(0, 399) == 0);
      enable = ($urandom_range(0, 9) != 0);
      for (int i = 0; i < 4; i++) req[i] = ($urandom_range(0, 11) == 0);
      tick(1);
    end
    reset = 1'b0; enable = 1'b1; req = 4'b0000;
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
